// File: rtl/gather_pkg.sv
// Shared types and helpers for the gather VC allocator.
package gather_pkg;

    // Ownership state of one output VC.
    typedef enum logic {
        VC_FREE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_e;

    // Width of a port index; never narrower than one bit.
    function automatic int unsigned port_idx_w(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/gather_va_arbiter.sv
// Per-output-VC arbiter: picks one winner among the eligible ports.
// Optional feature macro: GATHER_VA_ROUND_ROBIN_EN (round-robin pointer);
// without it the lowest-indexed eligible port wins.
module gather_va_arbiter
    import gather_pkg::*;
#(
    parameter int unsigned PORT_NUM = 5,
    localparam int unsigned PW = port_idx_w(PORT_NUM)
) (
`ifdef GATHER_VA_ROUND_ROBIN_EN
    input  logic                clk,
    input  logic                rstn,
`endif
    input  logic [PORT_NUM-1:0] elig_i,
    output logic                gnt_valid_o,
    output logic [PW-1:0]       gnt_idx_o
);

`ifdef GATHER_VA_ROUND_ROBIN_EN
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // First eligible port at or after the pointer; pointer moves past the winner.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int unsigned k = 0; k < PORT_NUM; k++) begin
            idx = (int unsigned'(ptr_q) + k) % PORT_NUM;
            if (!gnt_valid_o && elig_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = PW'(idx);
            end
        end
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = (gnt_idx_o == PW'(PORT_NUM - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest-indexed eligible port wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int unsigned k = 0; k < PORT_NUM; k++) begin
            if (!gnt_valid_o && elig_i[k]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = PW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/params.svh
// Global network parameters shared by the gather stage.
`ifndef GATHER_PARAMS_SVH
`define GATHER_PARAMS_SVH

// Number of output virtual channels per physical link.
`define CN 4

`endif

// File: rtl/gather_vc_allocator.sv
// Gather-stage output VC allocator: each output VC is FREE or owned by
// exactly one input port until that port's tail flit releases it.
// Optional feature macro: GATHER_VA_ROUND_ROBIN_EN (round-robin arbitration).
`include "params.svh"

module gather_vc_allocator
    import gather_pkg::*;
#(
    parameter int unsigned PORT_NUM = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [PORT_NUM*`CN-1:0] reqVC_i,
    input  logic [PORT_NUM-1:0]     release_i,
    output logic [PORT_NUM*`CN-1:0] selOutVC_o,
    output logic [PORT_NUM-1:0]     VCgranted_o,
    output logic [`CN-1:0]          vc_busy_o
);

    localparam int unsigned CN = `CN;
    localparam int unsigned PW = port_idx_w(PORT_NUM);

    vc_state_e           vc_state_q [CN];
    vc_state_e           vc_state_d [CN];
    logic [PW-1:0]       owner_q    [CN];
    logic [PW-1:0]       owner_d    [CN];
    logic [CN-1:0]       req_low    [PORT_NUM];
    logic [PORT_NUM-1:0] elig       [CN];
    logic [CN-1:0]       win_valid;
    logic [PW-1:0]       win_idx    [CN];

    // Reduce each port's request to its lowest set bit.
    always_comb begin
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            req_low[i] = reqVC_i[i*CN +: CN] & (~reqVC_i[i*CN +: CN] + 1'b1);
        end
    end

    // Outputs are decoded purely from the ownership registers, so reset clears them at once.
    always_comb begin
        selOutVC_o  = '0;
        VCgranted_o = '0;
        vc_busy_o   = '0;
        for (int unsigned v = 0; v < CN; v++) begin
            vc_busy_o[v] = (vc_state_q[v] == VC_BUSY);
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                if (vc_state_q[v] == VC_BUSY && owner_q[v] == PW'(i)) begin
                    selOutVC_o[i*CN + v] = 1'b1;
                    VCgranted_o[i]       = 1'b1;
                end
            end
        end
    end

    // A port competes for a VC only while it holds nothing and the VC is free.
    always_comb begin
        for (int unsigned v = 0; v < CN; v++) begin
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                elig[v][i] = req_low[i][v] && !VCgranted_o[i] && (vc_state_q[v] == VC_FREE);
            end
        end
    end

    for (genvar v = 0; v < CN; v++) begin : g_arb
        gather_va_arbiter #(
            .PORT_NUM (PORT_NUM)
        ) u_arb (
`ifdef GATHER_VA_ROUND_ROBIN_EN
            .clk         (clk),
            .rstn        (rstn),
`endif
            .elig_i      (elig[v]),
            .gnt_valid_o (win_valid[v]),
            .gnt_idx_o   (win_idx[v])
        );
    end

    // Release frees a busy VC; a free VC is taken by its winner. A VC freed
    // this edge was busy during arbitration, hence the one-cycle bubble.
    always_comb begin
        for (int unsigned v = 0; v < CN; v++) begin
            vc_state_d[v] = vc_state_q[v];
            owner_d[v]    = owner_q[v];
            if (vc_state_q[v] == VC_BUSY) begin
                if (release_i[owner_q[v]]) begin
                    vc_state_d[v] = VC_FREE;
                end
            end else if (win_valid[v]) begin
                vc_state_d[v] = VC_BUSY;
                owner_d[v]    = win_idx[v];
            end
        end
    end

    // VC ownership registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned v = 0; v < CN; v++) begin
                vc_state_q[v] <= VC_FREE;
                owner_q[v]    <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < CN; v++) begin
                vc_state_q[v] <= vc_state_d[v];
                owner_q[v]    <= owner_d[v];
            end
        end
    end

endmodule

// File: tb/tb_gather_vc_allocator.sv
// Self-checking bench for gather_vc_allocator (CN=4, PORT_NUM=5).
// Honours GATHER_VA_ROUND_ROBIN_EN when defined for the build.
module tb_gather_vc_allocator;

    localparam int CN = 4;
    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NP*CN-1:0] reqVC;
    logic [NP-1:0]    rel;
    logic [NP*CN-1:0] sel;
    logic [NP-1:0]    gnt;
    logic [CN-1:0]    busy;

    int total = 0;
    int bad   = 0;

    gather_vc_allocator #(
        .PORT_NUM (NP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .reqVC_i     (reqVC),
        .release_i   (rel),
        .selOutVC_o  (sel),
        .VCgranted_o (gnt),
        .vc_busy_o   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP*CN-1:0] req;
        logic [NP-1:0]    rl;
        logic [NP-1:0]    gnt;
        logic [CN-1:0]    busy;
        logic [NP*CN-1:0] sel;
    } vec_t;

    vec_t tbl [12];

    // Reference model: owner port per VC (-1 = free) and optional RR pointer.
    int owner [CN];
    int ptr   [CN];

    function automatic logic [NP*CN-1:0] rq(input int p, input logic [CN-1:0] v);
        logic [NP*CN-1:0] r;
        r = '0;
        r[p*CN +: CN] = v;
        return r;
    endfunction

    function automatic int lowbit(input logic [CN-1:0] r);
        for (int b = 0; b < CN; b++) begin
            if (r[b]) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < CN; v++) begin
            owner[v] = -1;
            ptr[v]   = 0;
        end
    endtask

    task automatic model_edge(input logic [NP*CN-1:0] r, input logic [NP-1:0] rl);
        int nxt [CN];
        bit held [NP];
        int p;
        int win;
        for (int i = 0; i < NP; i++) held[i] = 1'b0;
        for (int v = 0; v < CN; v++) if (owner[v] >= 0) held[owner[v]] = 1'b1;
        for (int v = 0; v < CN; v++) begin
            nxt[v] = owner[v];
            if (owner[v] >= 0) begin
                if (rl[owner[v]]) nxt[v] = -1;
            end else begin
                win = -1;
                for (int k = 0; k < NP; k++) begin
`ifdef GATHER_VA_ROUND_ROBIN_EN
                    p = (ptr[v] + k) % NP;
`else
                    p = k;
`endif
                    if (win < 0 && !held[p] && lowbit(r[p*CN +: CN]) == v) win = p;
                end
                if (win >= 0) begin
                    nxt[v] = win;
                    ptr[v] = (win + 1) % NP;
                end
            end
        end
        for (int v = 0; v < CN; v++) owner[v] = nxt[v];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [NP-1:0]    eg;
        logic [CN-1:0]    eb;
        logic [NP*CN-1:0] es;
        eg = '0; eb = '0; es = '0;
        for (int v = 0; v < CN; v++) begin
            if (owner[v] >= 0) begin
                eb[v] = 1'b1;
                eg[owner[v]] = 1'b1;
                es[owner[v]*CN + v] = 1'b1;
            end
        end
        chk({tag, "_gnt"},  32'(gnt),  32'(eg));
        chk({tag, "_busy"}, 32'(busy), 32'(eb));
        chk({tag, "_sel"},  32'(sel),  32'(es));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #7;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("watchdog expired before test end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NP*CN-1:0] cur;
        // {req, release, exp gnt, exp busy, exp sel}
        tbl[0]  = '{rq(2,4'b0100), 5'b00000, 5'b00100, 4'b0100, rq(2,4'b0100)};
        tbl[1]  = '{rq(2,4'b0100)|rq(1,4'b0001)|rq(3,4'b0001), 5'b00000, 5'b00110, 4'b0101, rq(2,4'b0100)|rq(1,4'b0001)};
        tbl[2]  = '{rq(2,4'b0100)|rq(1,4'b0001)|rq(3,4'b0001), 5'b00010, 5'b00100, 4'b0100, rq(2,4'b0100)};
        tbl[3]  = '{rq(2,4'b0100)|rq(3,4'b0001), 5'b00000, 5'b01100, 4'b0101, rq(2,4'b0100)|rq(3,4'b0001)};
        tbl[4]  = '{rq(0,4'b1010)|rq(2,4'b0100)|rq(3,4'b0001), 5'b00000, 5'b01101, 4'b0111, rq(0,4'b0010)|rq(2,4'b0100)|rq(3,4'b0001)};
        tbl[5]  = '{'0, 5'b01101, 5'b00000, 4'b0000, '0};
        tbl[6]  = '{'0, 5'b01000, 5'b00000, 4'b0000, '0};
        tbl[7]  = '{rq(4,4'b0100), 5'b00000, 5'b10000, 4'b0100, rq(4,4'b0100)};
        tbl[8]  = '{rq(4,4'b0100)|rq(0,4'b0100), 5'b10000, 5'b00000, 4'b0000, '0};
        tbl[9]  = '{rq(4,4'b0100)|rq(0,4'b0100), 5'b00000, 5'b00001, 4'b0100, rq(0,4'b0100)};
        tbl[10] = '{rq(0,4'b0001), 5'b00001, 5'b00000, 4'b0000, '0};
        tbl[11] = '{rq(0,4'b0001), 5'b00000, 5'b00001, 4'b0001, rq(0,4'b0001)};

        // Reset state, checked while rstn is still low.
        reqVC = '0;
        rel   = '0;
        rstn  = 1'b0;
        #12;
        chk("reset_gnt",  32'(gnt),  32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sel",  32'(sel),  32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vector table.
        for (int k = 0; k < 12; k++) begin
            reqVC = tbl[k].req;
            rel   = tbl[k].rl;
            step();
            chk($sformatf("vec%0d_gnt", k),  32'(gnt),  32'(tbl[k].gnt));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
            chk($sformatf("vec%0d_sel", k),  32'(sel),  32'(tbl[k].sel));
        end
        rel = '0;

        // Asynchronous reset with three VCs held mid-packet.
        reqVC = rq(0,4'b0001);
        rel   = 5'b00001;
        step();
        rel   = '0;
        reqVC = rq(1,4'b0001)|rq(2,4'b0010)|rq(3,4'b0100);
        step();
        chk("pre_rst_busy", 32'(busy), 32'h7);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_gnt",  32'(gnt),  32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_sel",  32'(sel),  32'd0);
        reqVC = '0;
        @(negedge clk);
        rstn  = 1'b1;
        reqVC = rq(4,4'b1000);
        step();
        chk("post_rst_gnt",  32'(gnt),  32'h10);
        chk("post_rst_busy", 32'(busy), 32'h8);
        chk("post_rst_sel",  32'(sel),  32'(rq(4,4'b1000)));

        // Repeated 1-vs-3 contest on VC0: RR alternates, fixed priority does not.
        reqVC = '0;
        do_reset();
        reqVC = rq(1,4'b0001)|rq(3,4'b0001);
        step();
        chk("contest1_gnt", 32'(gnt), 32'h02);
        rel = 5'b00010;
        step();
        rel = '0;
        chk("contest_bubble_gnt", 32'(gnt), 32'h00);
        step();
`ifdef GATHER_VA_ROUND_ROBIN_EN
        chk("contest2_gnt", 32'(gnt), 32'h08);
`else
        chk("contest2_gnt", 32'(gnt), 32'h02);
`endif

        // Randomized traffic against the reference model.
        reqVC = '0;
        rel   = '0;
        do_reset();
        model_reset();
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 2) == 0) cur[p*CN +: CN] = '0;
                    else cur[p*CN +: CN] = CN'($urandom_range(0, 15));
                end
                rel[p] = ($urandom_range(0, 5) == 0);
            end
            reqVC = cur;
            model_edge(reqVC, rel);
            step();
            chk_model($sformatf("rand%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gather_vc_allocator.md
GATHER_VC_ALLOCATOR -- requirements
Module: gather_vc_allocator

Interface
REQ-001 Parameter: PORT_NUM, default 5, number of gather input stages served.
REQ-002 Ports: clk  input  1  single clock; rising edge.
REQ-003 Ports: rstn  input  1  reset; asynchronous, active-low.
REQ-004 Ports: reqVC_i  input  PORT_NUM*`CN  per-port output-VC request from each input stage; slice i = bits [i*`CN +: `CN].
REQ-005 Ports: release_i  input  PORT_NUM  per-port pulse; the owning port's tail flit fired.
REQ-006 Ports: selOutVC_o  output  PORT_NUM*`CN  per-port one-hot granted output VC; all-zero when no grant.
REQ-007 Ports: VCgranted_o  output  PORT_NUM  per-port grant-held flag.
REQ-008 Ports: vc_busy_o  output  `CN  per-output-VC ownership flag.

Function
REQ-009 Each output VC v SHALL hold state FREE or BUSY(owner), where owner is a port index of width $clog2(PORT_NUM).
REQ-010 Port i SHALL be eligible for VC v when reqVC_i slice i has bit v set, VCgranted_o[i]=0, and v is FREE.
REQ-011 A multi-hot request SHALL be treated as its lowest set bit; an all-zero request SHALL request nothing.
REQ-012 Each FREE VC with at least one eligible port SHALL pick exactly one winner per cycle and become BUSY(winner) at the next clk edge.
REQ-013 Grant latency SHALL be 1 cycle: request sampled at edge N, VCgranted_o and selOutVC_o asserted after edge N.
REQ-014 VCgranted_o[i] and selOutVC_o[i] SHALL remain stable until the edge at which release_i[i] is sampled high.
REQ-015 A port SHALL own at most one VC; its request bits SHALL be ignored while it is granted.
REQ-016 release_i[i] while port i is granted SHALL return the owned VC to FREE and clear the port's grant at the next edge.
REQ-017 A released VC SHALL NOT be regranted at the release edge; it becomes eligible for arbitration from the following cycle (one-cycle bubble).
REQ-018 release_i[i] with port i not granted SHALL be ignored with no state change.
REQ-019 A request withdrawn before grant SHALL NOT be granted; no request memory is kept.
REQ-020 vc_busy_o[v] SHALL equal 1 exactly when v is BUSY.

Reset
REQ-021 On rstn low, all VCs SHALL go FREE, and VCgranted_o, selOutVC_o, vc_busy_o SHALL be 0 asynchronously.
REQ-022 Reset SHALL set all round-robin pointers to 0 and SHALL discard grants mid-packet with no release required.

Configuration
REQ-023 Macro GATHER_VA_ROUND_ROBIN_EN: when defined, each VC SHALL keep a round-robin pointer; the winner is the first eligible port at or after the pointer, and the pointer becomes (winner+1) mod PORT_NUM.
REQ-024 Without GATHER_VA_ROUND_ROBIN_EN, the winner SHALL be the lowest-indexed eligible port and no pointer state SHALL exist.

Structure
REQ-025 The VC state enum (FREE/BUSY) and the port-index width function SHALL be defined in the shared gather_pkg package; `CN SHALL come from params.svh.
REQ-026 A sub-module gather_va_arbiter (PORT_NUM-wide, one instance per output VC) SHALL hold the priority logic and the optional pointer.

Verification (CN=4, PORT_NUM=5)
REQ-027 Port 2 requests 4'b0100 in cycle 0 -> cycle 1: VCgranted_o[2]=1, selOutVC_o[2]=4'b0100, vc_busy_o=4'b0100.
REQ-028 Ports 1 and 3 both request VC0 in cycle 0 -> port 1 wins. After release, port 3 is granted 2 cycles later in both configurations. With GATHER_VA_ROUND_ROBIN_EN, a later 1/3 contest goes to port 3.
REQ-029 Port 0 requests 4'b1010 -> VC1 is granted; VC3 stays free.
REQ-030 Port 4 holds VC2 and release_i[4] pulses while port 0 requests VC2 -> VC2 is FREE for one cycle, then port 0 is granted.
REQ-031 release_i[3] pulses with port 3 idle -> no output changes.
REQ-032 rstn is dropped while 3 VCs are busy -> all outputs are 0 immediately. After rstn rises, a new request is granted with 1-cycle latency.
